fpga_l2_ram_bank: RTL and testbench

Parametrised, inferred block-RAM bank for L2 on the FPGA targets. It replaces fixed-size generated IP cores with a single module configured by parameters for data width, depth and read latency.
- Exposes a TCDM-style req/gnt/rvalid handshake.
- Optionally zero-initialises its full contents after reset through an internal sweep FSM.
- Sits between the L2 interconnect port and the RAM primitive, one instance per bank.

---
 rtl/fpga_l2_ram_bank.sv | 163 ++++++++++++++++
 tb/tb_fpga_l2_ram_bank.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_l2_ram_bank.sv
// L2 block-RAM bank with req/gnt/rvalid port, zero sweep (INIT_ZERO) and optional FPGA_RAM_PARITY_EN per-byte parity.
// Latency: READ_LATENCY (1 or 2) cycles from accept edge to rvalid_o; sweep takes DEPTH cycles.
// Backpressure: gnt_o withheld until init_done_o, then gnt_o = req_i; read data is never stalled.
module fpga_l2_ram_bank #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int INIT_ZERO    = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    init_done_o,
    output logic                    err_o
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);

    if (DATA_WIDTH % 8 != 0) begin : g_chk_dw
        $error("fpga_l2_ram_bank: DATA_WIDTH must be a multiple of 8");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_chk_lat
        $error("fpga_l2_ram_bank: READ_LATENCY must be 1 or 2");
    end

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] dat;
`ifdef FPGA_RAM_PARITY_EN
        logic [NB-1:0]         par;
`endif
    } rd_t;

    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic                  r_init_done;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                default: r_init_done <= 1'b1;
            endcase
        end
    end

    // The sweep owns the write port; requests are simply not granted meanwhile.
    logic                  w_sweep;
    logic                  w_acc;
    logic                  w_wr;
    logic                  w_rd;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdat;
    logic [NB-1:0]         w_be;

    assign w_sweep = (r_state == ST_INIT);
    assign w_acc   = req_i & r_init_done;
    assign w_wr    = w_sweep | (w_acc & we_i);
    assign w_rd    = w_acc & ~we_i;
    assign w_waddr = w_sweep ? r_cnt[ADDR_WIDTH-1:0] : addr_i;
    assign w_wdat  = w_sweep ? '0 : wdata_i;
    assign w_be    = w_sweep ? '1 : be_i;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
`ifdef FPGA_RAM_PARITY_EN
    logic [NB-1:0]         r_par [DEPTH];
`endif

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            for (int k = 0; k < NB; k++) begin
                if (w_be[k]) begin
                    r_mem[w_waddr][8*k +: 8] <= w_wdat[8*k +: 8];
`ifdef FPGA_RAM_PARITY_EN
                    r_par[w_waddr][k] <= ^w_wdat[8*k +: 8];
`endif
                end
            end
        end
    end

    rd_t w_rd_src;
    always_comb begin
        w_rd_src     = '0;
        w_rd_src.dat = r_mem[addr_i];
`ifdef FPGA_RAM_PARITY_EN
        w_rd_src.par = r_par[addr_i];
`endif
    end

    rd_t  r_s1;
    logic r_s1_vld;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_vld <= 1'b0;
            r_s1     <= '0;
        end else begin
            r_s1_vld <= w_rd;
            if (w_rd) r_s1 <= w_rd_src;
        end
    end

    rd_t  w_out;
    logic w_out_vld;

    if (READ_LATENCY == 2) begin : g_lat2
        rd_t  r_s2;
        logic r_s2_vld;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_s2_vld <= 1'b0;
                r_s2     <= '0;
            end else begin
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) r_s2 <= r_s1;
            end
        end
        assign w_out     = r_s2;
        assign w_out_vld = r_s2_vld;
    end else begin : g_lat1
        assign w_out     = r_s1;
        assign w_out_vld = r_s1_vld;
    end

    assign gnt_o       = w_acc;
    assign rvalid_o    = w_out_vld;
    assign rdata_o     = w_out.dat;
    assign init_done_o = r_init_done;

`ifdef FPGA_RAM_PARITY_EN
    logic [NB-1:0] w_par_bad;
    always_comb begin
        w_par_bad = '0;
        for (int k = 0; k < NB; k++) begin
            w_par_bad[k] = (^w_out.dat[8*k +: 8]) ^ w_out.par[k];
        end
    end
    assign err_o = w_out_vld & (|w_par_bad);
`else
    assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_fpga_l2_ram_bank.sv
// Two banks: A (latency 1, zero sweep) and B (latency 2, no sweep), each checked against a word-array model via a read scoreboard.
`timescale 1ns/1ps
module tb_fpga_l2_ram_bank;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n [2];
    logic          req   [2];
    logic          we    [2];
    logic [3:0]    be    [2];
    logic [AW-1:0] addr  [2];
    logic [31:0]   wdata [2];

    logic        gnt_a, rvalid_a, init_done_a, err_a;
    logic        gnt_b, rvalid_b, init_done_b, err_b;
    logic [31:0] rdata_a, rdata_b;

    fpga_l2_ram_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .READ_LATENCY(1), .INIT_ZERO(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n[0]), .req_i(req[0]), .gnt_o(gnt_a), .we_i(we[0]),
        .be_i(be[0]), .addr_i(addr[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid_a),
        .rdata_o(rdata_a), .init_done_o(init_done_a), .err_o(err_a)
    );

    fpga_l2_ram_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .READ_LATENCY(2), .INIT_ZERO(0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n[1]), .req_i(req[1]), .gnt_o(gnt_b), .we_i(we[1]),
        .be_i(be[1]), .addr_i(addr[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid_b),
        .rdata_o(rdata_b), .init_done_o(init_done_b), .err_o(err_b)
    );

    typedef struct {
        logic [31:0] dat;
        logic        err;
        int          cyc;
    } exp_t;

    logic [31:0] mm      [2][DEPTH];
    bit          corrupt [2][DEPTH];
    bit          ready   [2];
    logic [31:0] last    [2];
    exp_t        qa[$];
    exp_t        qb[$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic mon(input int s, input logic rn, input logic v, input logic [31:0] d,
                       input logic e, input int lat);
        exp_t  x;
        string nm;
        nm = (s == 0) ? "A" : "B";
        if (!rn) begin
            chk({nm, "_rvalid_in_reset"}, v, 32'd0);
            last[s] = '0;
            return;
        end
        if (v) begin
            if ((s == 0 && qa.size() == 0) || (s == 1 && qb.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL %s_spurious_rvalid: got rvalid=1 rdata=%h expected no pending read", nm, d);
                return;
            end
            if (s == 0) x = qa.pop_front();
            else        x = qb.pop_front();
            chk({nm, "_rdata"}, d, x.dat);
            chk({nm, "_err"}, e, {31'd0, x.err});
            chk({nm, "_latency_cycle"}, cyc, x.cyc + lat - 1);
            last[s] = x.dat;
        end else begin
            chk({nm, "_rdata_hold"}, d, last[s]);
            chk({nm, "_err_without_rvalid"}, e, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, rst_n[0], rvalid_a, rdata_a, err_a, 1);
        mon(1, rst_n[1], rvalid_b, rdata_b, err_b, 2);
    end

    // One request cycle; the model decides acceptance and pushes the expected read response.
    task automatic op(input int s, input bit r, input bit w, input logic [3:0] b,
                      input logic [AW-1:0] a, input logic [31:0] d);
        bit   acc;
        exp_t e;
        @(negedge clk);
        req[s] = r; we[s] = w; be[s] = b; addr[s] = a; wdata[s] = d;
        #1;
        acc = r && ready[s];
        chk($sformatf("%s_gnt", (s == 0) ? "A" : "B"), {31'd0, (s == 0) ? gnt_a : gnt_b}, {31'd0, acc});
        if (acc && w) begin
            for (int k = 0; k < 4; k++) if (b[k]) mm[s][a][8*k +: 8] = d[8*k +: 8];
            if (b[1]) corrupt[s][a] = 1'b0;
        end else if (acc) begin
            e.dat = mm[s][a];
            e.err = corrupt[s][a];
            e.cyc = cyc + 1;
            if (s == 0) qa.push_back(e);
            else        qb.push_back(e);
        end
    endtask

    task automatic idle(input int s, input int n);
        for (int i = 0; i < n; i++) op(s, 1'b0, 1'b0, 4'h0, '0, 32'h0);
    endtask

    task automatic rd(input int s, input logic [AW-1:0] a);
        op(s, 1'b1, 1'b0, 4'h0, a, 32'h0);
    endtask

    task automatic wr(input int s, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
        op(s, 1'b1, 1'b1, b, a, d);
    endtask

    // Called right after A's reset release: sweep must hold off grants for exactly DEPTH edges.
    task automatic init_check(input bit with_b);
        req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'h0; addr[0] = '0;
        for (int i = 0; i <= DEPTH; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk($sformatf("A_init_done_c%0d", i), {31'd0, init_done_a}, {31'd0, i == DEPTH});
            chk($sformatf("A_gnt_during_init_c%0d", i), {31'd0, gnt_a}, {31'd0, i == DEPTH});
            if (with_b) chk($sformatf("B_init_done_c%0d", i), {31'd0, init_done_b}, {31'd0, i > 0});
        end
        req[0] = 1'b0;
        ready[0] = 1'b1;
        for (int i = 0; i < DEPTH; i++) mm[0][i] = '0;
    endtask

    task automatic do_reset(input int s);
        @(negedge clk);
        #2;
        req[s] = 1'b0;
        rst_n[s] = 1'b0;
        ready[s] = 1'b0;
        if (s == 0) qa.delete();
        else        qb.delete();
        for (int i = 0; i < DEPTH; i++) corrupt[s][i] = 1'b0;
        @(negedge clk);
        #2;
        rst_n[s] = 1'b1;
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst_n[s] = 1'b1; req[s] = 1'b0; we[s] = 1'b0; be[s] = '0; addr[s] = '0; wdata[s] = '0;
            ready[s] = 1'b0; last[s] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                mm[s][i] = '0;
                corrupt[s][i] = 1'b0;
            end
        end
        #1;
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        ready[1] = 1'b1;
        init_check(1'b1);

        for (int i = 0; i < DEPTH; i++) rd(0, AW'(i));
        wr(0, 4'd3, 32'hDEADBEEF, 4'b1111);
        wr(0, 4'd3, 32'h000000AA, 4'b0001);
        rd(0, 4'd3);
        wr(0, 4'd7, 32'h00000005, 4'b1111);
        rd(0, 4'd7);
        wr(0, 4'd7, 32'hFFFFFFFF, 4'b0000);
        rd(0, 4'd7);
        idle(0, 2);

        for (int i = 0; i < DEPTH; i++) wr(1, AW'(i), $urandom, 4'hF);
        wr(1, 4'd1, 32'h11, 4'hF);
        wr(1, 4'd2, 32'h22, 4'hF);
        wr(1, 4'd3, 32'h33, 4'hF);
        rd(1, 4'd1);
        rd(1, 4'd2);
        rd(1, 4'd3);
        idle(1, 4);

`ifdef FPGA_RAM_PARITY_EN
        wr(0, 4'd3, 32'h01020304, 4'hF);
        wr(0, 4'd4, 32'h0A0B0C0D, 4'hF);
        idle(0, 1);
        @(negedge clk);
        #2;
        dut_a.r_mem[3][8] = ~dut_a.r_mem[3][8];
        mm[0][3][8] = ~mm[0][3][8];
        corrupt[0][3] = 1'b1;
        rd(0, 4'd3);
        rd(0, 4'd4);
        idle(0, 2);
`endif

        rd(1, 4'd9);
        do_reset(1);
        ready[1] = 1'b1;
        idle(1, 3);
        for (int i = 0; i < DEPTH; i++) rd(1, AW'(i));
        idle(1, 3);

        rd(0, 4'd7);
        do_reset(0);
        init_check(1'b0);
        for (int i = 0; i < DEPTH; i++) rd(0, AW'(i));
        idle(0, 2);

        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 300; n++) begin
                op(s, $urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), AW'($urandom), $urandom);
            end
            idle(s, 4);
        end

        chk("A_queue_drained", qa.size(), 32'd0);
        chk("B_queue_drained", qb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
